// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, the instruction memory read port and decode.
// The master side is the fetch unit; the slave side is memory plus decode.
interface fetch_unit_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, tracks the one-cycle memory read latency and
// buffers returned words in a small FIFO so decode can apply backpressure.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 12,
    parameter int          DEPTH    = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = CNT_W + 1;

    logic [31:0]      fetchPc_q, fetchPc_d;
    logic             inflight_q, inflight_d;
    logic [31:0]      inflightPc_q, inflightPc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [31:0]      fifoPc_q    [DEPTH];
    logic [31:0]      fifoInstr_q [DEPTH];

    logic             pop;
    logic             push;
    logic             issue;
    logic [OCC_W-1:0] occupancy;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign bus.out_valid = (count_q != '0);
    assign bus.out_pc    = bus.out_valid ? fifoPc_q[head_q]    : 32'h0;
    assign bus.out_instr = bus.out_valid ? fifoInstr_q[head_q] : 32'h0;
    assign bus.imem_addr = fetchPc_q[ADDR_W+1:2];

    assign pop  = bus.out_valid & bus.out_ready;
    assign push = inflight_q & ~bus.redirect_valid;

    // A read is only issued if a FIFO slot is guaranteed free when its data returns.
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    assign issue     = ~bus.redirect_valid & (occupancy < OCC_W'(DEPTH));

    always_comb begin
        fetchPc_d    = fetchPc_q;
        inflight_d   = 1'b0;
        inflightPc_d = inflightPc_q;
        count_d      = count_q;
        head_d       = head_q;
        tail_d       = tail_q;

        if (bus.redirect_valid) begin
            fetchPc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            count_d   = '0;
            head_d    = '0;
            tail_d    = '0;
        end else begin
            if (issue) begin
                inflight_d   = 1'b1;
                inflightPc_d = fetchPc_q;
                fetchPc_d    = fetchPc_q + 32'd4;
            end
            if (push) begin
                tail_d = nextPtr(tail_q);
            end
            if (pop) begin
                head_d = nextPtr(head_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc_q    <= RESET_PC;
            inflight_q   <= 1'b0;
            inflightPc_q <= 32'h0;
            count_q      <= '0;
            head_q       <= '0;
            tail_q       <= '0;
        end else begin
            fetchPc_q    <= fetchPc_d;
            inflight_q   <= inflight_d;
            inflightPc_q <= inflightPc_d;
            count_q      <= count_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
        end
    end

    // Payload storage needs no reset; the outputs are gated by the entry count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifoPc_q[tail_q]    <= inflightPc_q;
            fifoInstr_q[tail_q] <= bus.imem_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a registered memory model, expected
// {pc, instr} streams queued at each (re)start and checked on every handshake.
module tb_fetch_unit;
    localparam int          ADDR_W   = 12;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC  = 32'h0000_3FFC;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();
    fetch_unit_if #(.ADDR_W(ADDR_W)) wrapBus ();

    fetch_unit #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .ADDR_W(ADDR_W), .DEPTH(2)) wrapDut (
        .clk   (clk),
        .reset (reset),
        .bus   (wrapBus)
    );

    logic [63:0] expQ [$];
    logic [63:0] expHead;
    int          popCount    = 0;
    int          vectorCount = 0;
    int          missCount   = 0;

    function automatic logic [31:0] memWord(input logic [ADDR_W-1:0] addr);
        return 32'h100 + {{(32 - ADDR_W){1'b0}}, addr};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            bus.imem_data     <= 32'h0;
            wrapBus.imem_data <= 32'h0;
        end else begin
            bus.imem_data     <= memWord(bus.imem_addr);
            wrapBus.imem_data <= memWord(wrapBus.imem_addr);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic redirValid, input logic [31:0] redirPc);
        bus.out_ready      = rdy;
        bus.redirect_valid = redirValid;
        bus.redirect_pc    = redirPc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startStream(input logic [31:0] pc);
        logic [31:0] p;
        expQ.delete();
        p = pc & 32'hFFFF_FFFC;
        repeat (128) begin
            expQ.push_back({p, memWord(p[ADDR_W+1:2])});
            p = p + 32'd4;
        end
    endtask

    task automatic waitDeliveries(input int n, input int budget);
        int target;
        int cyc;
        target = popCount + n;
        cyc    = 0;
        while (popCount < target && cyc < budget) begin
            tick();
            cyc++;
        end
        checkOutput("deliverCount", 32'(popCount >= target), 32'd1);
    endtask

    task automatic doReset(input logic rdy);
        reset = 1'b1;
        applyStimulus(rdy, 1'b0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        startStream(RESET_PC);
        checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstPc", bus.out_pc, 32'h0);
        checkOutput("rstInstr", bus.out_instr, 32'h0);
        checkOutput("rstAddr", 32'(bus.imem_addr), 32'(RESET_PC[ADDR_W+1:2]));
        checkOutput("wrapRstAddr", 32'(wrapBus.imem_addr), 32'hFFF);
    endtask

    // Every accepted handshake must match the head of the expected stream.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("sbUnderrun", 32'd1, 32'd0);
            end else begin
                expHead = expQ.pop_front();
                checkOutput("outPc", bus.out_pc, expHead[63:32]);
                checkOutput("outInstr", bus.out_instr, expHead[31:0]);
                popCount++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        wrapBus.out_ready      = 1'b1;
        wrapBus.redirect_valid = 1'b0;
        wrapBus.redirect_pc    = 32'h0;
        applyStimulus(1'b1, 1'b0, 32'h0);

        doReset(1'b1);
        tick();
        checkOutput("firstCycleValid", 32'(bus.out_valid), 32'd0);
        checkOutput("wrapAddr", 32'(wrapBus.imem_addr), 32'h000);
        tick();
        checkOutput("firstValid", 32'(bus.out_valid), 32'd1);
        checkOutput("firstPc", bus.out_pc, 32'h0);
        checkOutput("firstInstr", bus.out_instr, 32'h100);
        checkOutput("wrapPc0", wrapBus.out_pc, 32'h3FFC);
        checkOutput("wrapInstr0", wrapBus.out_instr, 32'h10FF);
        tick();
        checkOutput("streamPc", bus.out_pc, 32'h4);
        checkOutput("wrapPc1", wrapBus.out_pc, 32'h4000);
        checkOutput("wrapInstr1", wrapBus.out_instr, 32'h100);
        waitDeliveries(8, 20);

        doReset(1'b0);
        w = 0;
        while (!bus.out_valid && w < 10) begin
            tick();
            w++;
        end
        checkOutput("bpValid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("holdPc", bus.out_pc, 32'h0);
            checkOutput("holdValid", 32'(bus.out_valid), 32'd1);
            checkOutput("holdAddr", 32'(bus.imem_addr), 32'd2);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitDeliveries(6, 20);

        applyStimulus(1'b1, 1'b1, 32'h40);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        startStream(32'h40);
        checkOutput("redirValid", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("redirIssueValid", 32'(bus.out_valid), 32'd0);
        tick();
        checkOutput("redirLatValid", 32'(bus.out_valid), 32'd1);
        checkOutput("redirLatPc", bus.out_pc, 32'h40);
        checkOutput("redirLatInstr", bus.out_instr, 32'h110);
        waitDeliveries(4, 20);

        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (4) tick();
        applyStimulus(1'b0, 1'b1, 32'h7);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        startStream(32'h4);
        checkOutput("misValid", 32'(bus.out_valid), 32'd0);
        checkOutput("misAddr", 32'(bus.imem_addr), 32'd1);
        waitDeliveries(4, 20);

        applyStimulus(1'b1, 1'b1, 32'h10);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h20);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        startStream(32'h20);
        checkOutput("b2bAddr", 32'(bus.imem_addr), 32'd8);
        waitDeliveries(4, 20);

        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, 32'h0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitDeliveries(3, 20);

        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (4) tick();
        checkOutput("fullValid", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("midRstValid", 32'(bus.out_valid), 32'd0);
        checkOutput("midRstAddr", 32'(bus.imem_addr), 32'(RESET_PC[ADDR_W+1:2]));
        checkOutput("midRstPc", bus.out_pc, 32'h0);
        checkOutput("midRstWrapAddr", 32'(wrapBus.imem_addr), 32'hFFF);
        reset = 1'b0;
        startStream(RESET_PC);
        applyStimulus(1'b1, 1'b0, 32'h0);
        waitDeliveries(4, 20);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
